mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single external memory bus (Addr/Bus/Read/Write/Valid) between the instruction-cache fill port and the data-cache fill/write port inside the CPU. Each cache presents a request. The arbiter grants one requester at a time, sequences the multi-beat line fill or the single-word write-through on the memory side, and returns fill words to the granted cache. It enforces the memory system's rule that Read drops after the last beat and stays low long enough for the memory to re-arm.

## Interface
- WORDS_PER_LINE, 8: beats per line fill (32-byte lines, 32-bit words); must be a power of 2.
- OFFSET_BITS, 5: byte-offset bits cleared from fill addresses.
- CLK  in  1  system clock; all state updates on posedge.
- MRST  in  1  reset, asynchronous, active-low.
- ic_req  in  1  I$ line-fill request; held until ic_done.
- ic_addr  in  32  I$ miss address; stable while ic_req.
- ic_gnt  out  1  I$ owns the bus.
- ic_rvalid  out  1  ic_rdata holds a fill word this cycle.
- ic_rdata  out  32  fill word, beats in ascending address order.
- ic_done  out  1  one-cycle pulse: I$ transaction complete.
- dc_req  in  1  D$ request; held until dc_done.
- dc_we  in  1  1 = single-word write, 0 = line fill; stable while dc_req.
- dc_addr  in  32  D$ address; stable while dc_req.
- dc_wdata  in  32  write data; stable while dc_req.
- dc_gnt, dc_rvalid, dc_rdata, dc_done: D$ equivalents of the I$ outputs.
- Addr  out  32  memory address.
- Read  out  1  memory fill request.
- Write  out  1  memory word write strobe.
- Bus  inout  32  driven with dc_wdata only while Write=1, else high-Z.
- Valid  in  1  memory fill word present on Bus.

## Operation
- States: IDLE, FILL, WRITE, GAP.
- Reset (MRST low, asynchronous): state IDLE. Read, Write, all gnt, rvalid and done outputs are 0. Addr, rdata and the beat counter are 0. last_grant is I$, so D$ wins the first conflict. Bus is high-Z.
- IDLE: on a posedge, select a requester.
  - One req high: select it.
  - Both high: select the one not equal to last_grant (round-robin).
  - Update last_grant and assert the winner's gnt.
  - Fill request: go to FILL, Read=1, Addr = {addr[31:OFFSET_BITS], OFFSET_BITS'b0}.
  - D$ write: go to WRITE, Write=1, Addr = dc_addr, Bus = dc_wdata.
- FILL: on each posedge with Valid=1:
  - capture Bus into the winner's rdata and pulse its rvalid the next cycle;
  - increment the beat counter (log2(WORDS_PER_LINE) bits, wraps to 0).
  - Valid=0 cycles are wait states; there is no timeout.
  - On capturing beat WORDS_PER_LINE-1, go to GAP and drop Read.
- WRITE: exactly one cycle, then GAP with Write=0 and Bus high-Z.
- GAP: one cycle. Read=Write=0, the winner's done=1, then gnt drops and the state returns to IDLE.
- Requests that arrive while busy wait. They are sampled only in IDLE.
- The losing requester's outputs stay 0 throughout.
- The beat counter resets to 0 on every grant.

## Timing
- Grant latency: req sampled high at edge E gives gnt, Read/Write and Addr valid after E.
- Fill data: Valid sampled at edge V gives rvalid/rdata valid in cycle V..V+1 (one-cycle registered latency).
- Read deassertion: the last beat captured at edge L takes Read low after L.
  - GAP occupies L..L+1 and the state is IDLE at L+1.
  - The earliest new Read is after edge L+2.
  - Read is therefore low for at least 2 cycles, which lets memory clear its scheduled flag.
- Write occupancy: Write is high for exactly one cycle. A back-to-back write can start 2 cycles later at the earliest.
- done pulses in the cycle after the final beat or write. The requester may drop req in the cycle following done. If req is still high at the IDLE sample, that is a new request.
- Reset mid-FILL or mid-WRITE: outputs clear immediately (asynchronous). No done is issued and partial rdata is discarded.

## Test plan
- I$ fill alone: ic_req, ic_addr=0x0000_1234; memory returns 8 Valid beats 0xA0..0xA7.
  - Required: Addr=0x0000_1220.
  - Required: 8 ic_rvalid pulses with rdata 0xA0..0xA7 in order.
  - Required: Read low after the 8th beat, then ic_done one cycle, then dc_* stay 0.
- D$ write: dc_req, dc_we=1, dc_addr=0x40, dc_wdata=0xDEADBEEF.
  - Required: one cycle with Write=1, Addr=0x40 and Bus=0xDEADBEEF.
  - Required: Bus high-Z after that, then dc_done one cycle later.
- Simultaneous ic_req and dc_req (fills) after reset.
  - Required: D$ is served first, then I$ after D$ done plus 1 IDLE cycle.
  - Required: a repeat conflict then grants I$ first.
- Valid stalls: insert 3 Valid=0 cycles between beats 2 and 3.
  - Required: counter holds, no spurious rvalid, and 8 beats total.
- Gap rule: I$ fill followed immediately by a held dc_req.
  - Required: Read low for at least 2 consecutive cycles between the two fills.
- MRST low during beat 4 of a fill.
  - Required: Read, gnt and rvalid are 0 immediately; no done.
  - Required: after MRST high, a fresh request starts at beat 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single external memory bus between the I$ fill port and the D$ fill/write port.
// One owner at a time; every transaction ends with a GAP cycle so Read stays low long enough for memory to re-arm.
module mem_bus_arbiter #(
    parameter int WORDS_PER_LINE = 8,
    parameter int OFFSET_BITS    = 5
) (
    input  logic        CLK,
    input  logic        MRST,

    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_gnt,
    output logic        ic_rvalid,
    output logic [31:0] ic_rdata,
    output logic        ic_done,

    input  logic        dc_req,
    input  logic        dc_we,
    input  logic [31:0] dc_addr,
    input  logic [31:0] dc_wdata,
    output logic        dc_gnt,
    output logic        dc_rvalid,
    output logic [31:0] dc_rdata,
    output logic        dc_done,

    output logic [31:0] Addr,
    output logic        Read,
    output logic        Write,
    inout  wire  [31:0] Bus,
    input  logic        Valid
);

    localparam int              BEAT_W    = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
    localparam logic [31:0]     LINE_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic GRANT_IC = 1'b0;
    localparam logic GRANT_DC = 1'b1;

    logic [1:0]        r_state;
    logic              r_lastGrant;
    logic [BEAT_W-1:0] r_beat;

    wire w_anyReq;
    wire w_pickDc;

    // r_lastGrant doubles as the current owner once a grant is made.
    assign w_anyReq = ic_req | dc_req;
    assign w_pickDc = dc_req & (~ic_req | (r_lastGrant == GRANT_IC));

    assign Bus = Write ? dc_wdata : {32{1'bz}};

    always_ff @(posedge CLK or negedge MRST) begin
        if (!MRST) begin
            r_state     <= S_IDLE;
            r_lastGrant <= GRANT_IC;
            r_beat      <= '0;
            Addr        <= '0;
            Read        <= 1'b0;
            Write       <= 1'b0;
            ic_gnt      <= 1'b0;
            ic_rvalid   <= 1'b0;
            ic_rdata    <= '0;
            ic_done     <= 1'b0;
            dc_gnt      <= 1'b0;
            dc_rvalid   <= 1'b0;
            dc_rdata    <= '0;
            dc_done     <= 1'b0;
        end else begin
            ic_rvalid <= 1'b0;
            dc_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_anyReq) begin
                        r_lastGrant <= w_pickDc;
                        r_beat      <= '0;
                        if (w_pickDc) begin
                            dc_gnt <= 1'b1;
                            if (dc_we) begin
                                r_state <= S_WRITE;
                                Write   <= 1'b1;
                                Addr    <= dc_addr;
                            end else begin
                                r_state <= S_FILL;
                                Read    <= 1'b1;
                                Addr    <= dc_addr & LINE_MASK;
                            end
                        end else begin
                            ic_gnt  <= 1'b1;
                            r_state <= S_FILL;
                            Read    <= 1'b1;
                            Addr    <= ic_addr & LINE_MASK;
                        end
                    end
                end
                S_FILL: begin
                    if (Valid) begin
                        if (r_lastGrant == GRANT_DC) begin
                            dc_rdata  <= Bus;
                            dc_rvalid <= 1'b1;
                        end else begin
                            ic_rdata  <= Bus;
                            ic_rvalid <= 1'b1;
                        end
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == LAST_BEAT) begin
                            r_state <= S_GAP;
                            Read    <= 1'b0;
                            if (r_lastGrant == GRANT_DC) dc_done <= 1'b1;
                            else                         ic_done <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    Write   <= 1'b0;
                    dc_done <= 1'b1;
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    ic_done <= 1'b0;
                    dc_done <= 1'b0;
                    ic_gnt  <= 1'b0;
                    dc_gnt  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; the bench plays both caches and the memory.
module tb_mem_bus_arbiter;

    logic        CLK = 1'b0;
    logic        MRST;
    logic        ic_req, dc_req, dc_we, Valid;
    logic [31:0] ic_addr, dc_addr, dc_wdata, memData;
    logic        ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done;
    logic [31:0] ic_rdata, dc_rdata, Addr;
    logic        Read, Write;
    wire  [31:0] Bus;

    int total = 0;
    int bad   = 0;

    assign Bus = Valid ? memData : {32{1'bz}};

    always #5 CLK = ~CLK;

    mem_bus_arbiter #(.WORDS_PER_LINE(8), .OFFSET_BITS(5)) dut (
        .CLK(CLK), .MRST(MRST),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
        .ic_rdata(ic_rdata), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_done(dc_done),
        .Addr(Addr), .Read(Read), .Write(Write), .Bus(Bus), .Valid(Valid)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic icReq, input logic [31:0] icAddr, input logic dcReq,
                                 input logic dcWe, input logic [31:0] dcAddr, input logic [31:0] dcWdata);
        ic_req   = icReq;
        ic_addr  = icAddr;
        dc_req   = dcReq;
        dc_we    = dcWe;
        dc_addr  = dcAddr;
        dc_wdata = dcWdata;
    endtask

    task automatic step;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    function automatic logic [31:0] sideFlags(input bit isDc);
        return isDc ? {29'd0, dc_gnt, dc_rvalid, dc_done} : {29'd0, ic_gnt, ic_rvalid, ic_done};
    endfunction

    function automatic logic [31:0] sideData(input bit isDc);
        return isDc ? dc_rdata : ic_rdata;
    endfunction

    // Entered on the negedge just after the grant edge; leaves on the GAP negedge (or mid-line).
    task automatic serveFill(input bit isDc, input logic [31:0] expAddr, input logic [31:0] base,
                             input int stallBeat, input int stallCycles, input int nBeats);
        checkOutput("grantFlags", sideFlags(isDc), 32'b100);
        checkOutput("loserIdle", sideFlags(!isDc), 32'd0);
        checkOutput("readUp", {31'd0, Read}, 32'd1);
        checkOutput("fillAddr", Addr, expAddr);
        for (int b = 0; b < nBeats; b++) begin
            if (b == stallBeat) begin
                for (int k = 0; k < stallCycles; k++) begin
                    Valid = 1'b0;
                    step;
                    checkOutput("stallFlags", sideFlags(isDc), 32'b100);
                    checkOutput("stallRead", {31'd0, Read}, 32'd1);
                end
            end
            Valid   = 1'b1;
            memData = base + 32'(b);
            step;
            Valid = 1'b0;
            checkOutput("beatFlags", sideFlags(isDc), (b == 7) ? 32'b111 : 32'b110);
            checkOutput("beatData", sideData(isDc), base + 32'(b));
            checkOutput("beatRead", {31'd0, Read}, (b == 7) ? 32'd0 : 32'd1);
            checkOutput("beatLoser", sideFlags(!isDc), 32'd0);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput(tag, {26'd0, ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done} |
                         {30'd0, Read, Write}, 32'd0);
    endtask

    initial begin
        MRST    = 1'b0;
        Valid   = 1'b0;
        memData = 32'd0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        checkIdle("resetOutputs");
        checkOutput("resetAddr", Addr, 32'd0);
        checkOutput("resetIcData", ic_rdata, 32'd0);
        checkOutput("resetDcData", dc_rdata, 32'd0);
        @(negedge CLK);
        MRST = 1'b1;

        // Plain I$ line fill
        applyStimulus(1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'd0, 32'd0);
        step;
        serveFill(1'b0, 32'h0000_1220, 32'hA0, -1, 0, 8);
        ic_req = 1'b0;
        step;
        checkIdle("icFillEnd");

        // D$ single-word write-through
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        step;
        checkOutput("wrFlags", {29'd0, dc_gnt, Write, Read}, 32'b110);
        checkOutput("wrAddr", Addr, 32'h40);
        checkOutput("wrBus", Bus, 32'hDEAD_BEEF);
        step;
        checkOutput("wrGapFlags", {29'd0, Write, dc_gnt, dc_done}, 32'b011);
        dc_req = 1'b0;
        step;
        checkIdle("wrEnd");

        // Valid stalls between beats 2 and 3
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0, 32'd0);
        step;
        serveFill(1'b0, 32'h0000_0100, 32'h10, 3, 3, 8);
        ic_req = 1'b0;
        step;
        checkIdle("stallEnd");

        // I$ fill followed by a held D$ fill request: Read must stay low two cycles
        applyStimulus(1'b1, 32'h0000_0600, 1'b0, 1'b0, 32'd0, 32'd0);
        step;
        applyStimulus(1'b1, 32'h0000_0600, 1'b1, 1'b0, 32'h5004, 32'd0);
        serveFill(1'b0, 32'h0000_0600, 32'h60, -1, 0, 8);
        ic_req = 1'b0;
        step;
        checkOutput("gapRead2", {31'd0, Read}, 32'd0);
        checkOutput("gapNoGnt", {30'd0, ic_gnt, dc_gnt}, 32'd0);
        step;
        serveFill(1'b1, 32'h0000_5000, 32'h50, -1, 0, 8);
        dc_req = 1'b0;
        step;
        checkIdle("gapEnd");

        // Conflict right after reset: D$ first, then I$ wins the repeat conflict
        MRST = 1'b0;
        step;
        MRST = 1'b1;
        applyStimulus(1'b1, 32'h0000_2000, 1'b1, 1'b0, 32'h3010, 32'd0);
        step;
        serveFill(1'b1, 32'h0000_3000, 32'hB0, -1, 0, 8);
        step;
        checkIdle("conflictIdle");
        step;
        serveFill(1'b0, 32'h0000_2000, 32'hD0, -1, 0, 8);
        ic_req = 1'b0;
        step;
        checkIdle("conflictIdle2");
        step;
        serveFill(1'b1, 32'h0000_3000, 32'hC0, -1, 0, 8);
        dc_req = 1'b0;
        step;
        checkIdle("conflictEnd");

        // Reset asserted while beat 4 is on the bus
        applyStimulus(1'b1, 32'h0000_7000, 1'b0, 1'b0, 32'd0, 32'd0);
        step;
        serveFill(1'b0, 32'h0000_7000, 32'h70, -1, 0, 4);
        Valid   = 1'b1;
        memData = 32'h74;
        #2 MRST = 1'b0;
        #1;
        checkOutput("rstFlags", {29'd0, ic_gnt, ic_rvalid, ic_done}, 32'd0);
        checkOutput("rstRead", {31'd0, Read}, 32'd0);
        Valid = 1'b0;
        step;
        checkOutput("rstNoDone", {30'd0, ic_done, dc_done}, 32'd0);
        step;
        checkOutput("rstNoDone2", {30'd0, ic_done, dc_done}, 32'd0);
        MRST = 1'b1;
        step;
        serveFill(1'b0, 32'h0000_7000, 32'hE0, -1, 0, 8);
        ic_req = 1'b0;
        step;
        checkIdle("rstEnd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
